// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: clocked main-memory model serving whole cache lines
// over a narrow command/data bus with fixed latency and multi-beat bursts.
//
// Ports:
//   clk    rising-edge clock
//   R      synchronous active-low reset
//   c_in   command: 0 NOP, 1 reserved (NOP), 2 READ_LINE, 3 WRITE_LINE
//   a_in   line address, sampled on the command cycle only
//   d_in   write-data beat
//   c_out  0 NOP, 1 RESPONSE
//   d_out  read-data beat, 0 whenever c_out is not RESPONSE
//   busy   high in every state except IDLE
module line_mem_ctrl #(
   parameter int         ADDR_W     = 15,
   parameter int         LINE_BYTES = 16,
   parameter int         BUS_W      = 16,
   parameter int         LATENCY    = 100,
   parameter logic [7:0] SEED       = 8'hA5
) (
   input  logic              clk,
   input  logic              R,
   input  logic [1:0]        c_in,
   input  logic [ADDR_W-1:0] a_in,
   input  logic [BUS_W-1:0]  d_in,
   output logic [1:0]        c_out,
   output logic [BUS_W-1:0]  d_out,
   output logic              busy
);

   localparam int LINE_W = LINE_BYTES * 8;
   localparam int BEATS  = LINE_W / BUS_W;
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int CNT_W  = $clog2(LATENCY + BEATS + 1);

   localparam logic [1:0] CMD_RD = 2'd2;
   localparam logic [1:0] CMD_WR = 2'd3;

   typedef enum logic [2:0] {
      IDLE, WR_COLLECT, WAIT, RD_RESP, WR_ACK
   } state_t;

   state_t             state_q;
   logic               op_wr_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   beat_q;
   logic [LINE_W-1:0]  line_q;
   logic [1:0]         c_out_q;
   logic [BUS_W-1:0]   d_out_q;

   // Storage holds (data XOR seed pattern), so an all-zero power-up
   // image reads back as the seed pattern without any reset sweep.
   logic [LINE_W-1:0]  mem [2**ADDR_W];

   logic [LINE_W-1:0]  shift_d;
   logic [LINE_W-1:0]  rd_line_d;
   logic [ADDR_W-1:0]  wa_d;
   logic               we_d;

   function automatic logic [LINE_W-1:0] seed_line(
      input logic [ADDR_W-1:0] a
   );
      logic [7:0] b;
      seed_line = '0;
      for (int j = 0; j < LINE_BYTES; j++) begin
         b = 8'((32'(a) << OFF_W) | 32'(j));
         seed_line[j*8 +: 8] = b ^ SEED;
      end
   endfunction

   // Beats enter at the top and shift down, so beat 0 ends up in the
   // low bits after BEATS captures.
   assign shift_d = (line_q >> BUS_W)
                  | (LINE_W'(d_in) << (LINE_W - BUS_W));

   assign rd_line_d = mem[a_in] ^ seed_line(a_in);

   assign wa_d = (state_q == IDLE) ? a_in : addr_q;

   // Commit edge: last beat of a collect, or the command edge itself
   // when a line is a single beat.  Reset on that edge blocks it.
   assign we_d = R && (
      ((BEATS == 1) && (state_q == IDLE) && (c_in == CMD_WR)) ||
      ((state_q == WR_COLLECT) && (beat_q == CNT_W'(BEATS - 1))));

   always_ff @(posedge clk) begin
      if (we_d) begin
         mem[wa_d] <= shift_d ^ seed_line(wa_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         state_q <= IDLE;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         beat_q  <= '0;
         line_q  <= '0;
         c_out_q <= 2'd0;
         d_out_q <= '0;
      end else begin
         c_out_q <= 2'd0;
         d_out_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (c_in == CMD_RD) begin
                  addr_q  <= a_in;
                  op_wr_q <= 1'b0;
                  line_q  <= rd_line_d;
                  cnt_q   <= CNT_W'(LATENCY - 1);
                  state_q <= WAIT;
               end else if (c_in == CMD_WR) begin
                  addr_q  <= a_in;
                  op_wr_q <= 1'b1;
                  line_q  <= shift_d;
                  beat_q  <= CNT_W'(1);
                  cnt_q   <= CNT_W'(LATENCY - 1);
                  state_q <= (BEATS == 1) ? WAIT : WR_COLLECT;
               end
            end
            WR_COLLECT: begin
               line_q <= shift_d;
               beat_q <= beat_q + CNT_W'(1);
               if (beat_q == CNT_W'(BEATS - 1)) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  c_out_q <= 2'd1;
                  if (op_wr_q) begin
                     state_q <= WR_ACK;
                  end else begin
                     d_out_q <= line_q[BUS_W-1:0];
                     line_q  <= line_q >> BUS_W;
                     beat_q  <= CNT_W'(1);
                     state_q <= RD_RESP;
                  end
               end
            end
            RD_RESP: begin
               if (beat_q == CNT_W'(BEATS)) begin
                  state_q <= IDLE;
               end else begin
                  c_out_q <= 2'd1;
                  d_out_q <= line_q[BUS_W-1:0];
                  line_q  <= line_q >> BUS_W;
                  beat_q  <= beat_q + CNT_W'(1);
               end
            end
            WR_ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign c_out = c_out_q;
   assign d_out = d_out_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb_line_mem_ctrl: directed vector bench for line_mem_ctrl
// (default build plus a LATENCY=1, single-beat build).
module tb_line_mem_ctrl;

   logic         clk = 1'b0;
   logic         R;
   logic [1:0]   c_in, c_out;
   logic [14:0]  a_in;
   logic [15:0]  d_in, d_out;
   logic         busy;
   logic [1:0]   c1_in, c1_out;
   logic [14:0]  a1_in;
   logic [127:0] d1_in, d1_out;
   logic         busy1;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   line_mem_ctrl u0 (
      .clk(clk), .R(R), .c_in(c_in), .a_in(a_in), .d_in(d_in),
      .c_out(c_out), .d_out(d_out), .busy(busy)
   );

   line_mem_ctrl #(.LATENCY(1), .BUS_W(128)) u1 (
      .clk(clk), .R(R), .c_in(c1_in), .a_in(a1_in), .d_in(d1_in),
      .c_out(c1_out), .d_out(d1_out), .busy(busy1)
   );

   typedef struct packed {
      logic             wr;
      logic [14:0]      a;
      logic [7:0][15:0] d;
   } vec_t;

   vec_t        vecs[9];
   logic [15:0] rd_beats[8];

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] seed16(input logic [14:0] a,
                                          input int i);
      logic [18:0] ba;
      logic [7:0]  b0, b1;
      ba = {a, 4'(2 * i)};
      b0 = ba[7:0] ^ 8'hA5;
      b1 = (ba[7:0] + 8'd1) ^ 8'hA5;
      return {b1, b0};
   endfunction

   function automatic logic [127:0] seed128(input logic [14:0] a);
      logic [18:0] ba;
      seed128 = '0;
      for (int j = 0; j < 16; j++) begin
         ba = {a, 4'(j)};
         seed128[j*8 +: 8] = ba[7:0] ^ 8'hA5;
      end
   endfunction

   task automatic wait_resp(input string tag);
      int n;
      n = 0;
      while (c_out != 2'd1 && n < 300) begin
         tick();
         n++;
      end
      chk({tag, " latency"}, n, 100);
   endtask

   task automatic do_op(input vec_t v, input bit junk,
                        input string tag);
      int n;
      if (!v.wr) begin
         c_in = 2'd2;
         a_in = v.a;
         tick();
         c_in = 2'd0;
         a_in = 15'h1234;
         chk({tag, " busy"}, busy, 1);
         chk({tag, " idle cout"}, c_out, 0);
         n = 0;
         while (c_out != 2'd1 && n < 300) begin
            if (junk && n < 10) begin
               c_in = 2'd3;
               a_in = v.a;
               d_in = 16'hFFFF;
            end else begin
               c_in = 2'd0;
            end
            tick();
            n++;
         end
         c_in = 2'd0;
         chk({tag, " latency"}, n, 100);
         for (int i = 0; i < 8; i++) begin
            rd_beats[i] = d_out;
            chk($sformatf("%s cout%0d", tag, i), c_out, 1);
            chk($sformatf("%s beat%0d", tag, i), d_out, v.d[i]);
            tick();
         end
         chk({tag, " end busy"}, busy, 0);
         chk({tag, " end cout"}, c_out, 0);
         chk({tag, " end dout"}, d_out, 0);
      end else begin
         c_in = 2'd3;
         a_in = v.a;
         d_in = v.d[0];
         tick();
         c_in = 2'd0;
         a_in = 15'h1234;
         for (int i = 1; i < 8; i++) begin
            chk($sformatf("%s busy%0d", tag, i), busy, 1);
            d_in = v.d[i];
            tick();
         end
         d_in = 16'h0;
         wait_resp(tag);
         chk({tag, " ack dout"}, d_out, 0);
         tick();
         chk({tag, " ack one cycle"}, c_out, 0);
         chk({tag, " end busy"}, busy, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         vecs[0].d[i] = seed16(15'd1, i);
         vecs[1].d[i] = 16'(i + 1);
         vecs[2].d[i] = 16'(i + 1);
         vecs[3].d[i] = 16'hA0B0 + 16'(i * 16'h0101);
         vecs[4].d[i] = 16'hA0B0 + 16'(i * 16'h0101);
         vecs[5].d[i] = seed16(15'h7FFE, i);
         vecs[6].d[i] = seed16(15'd0, i);
         vecs[7].d[i] = seed16(15'd1, i);
         vecs[8].d[i] = seed16(15'd1, i);
      end
      vecs[0].wr = 0; vecs[0].a = 15'd1;
      vecs[1].wr = 1; vecs[1].a = 15'd5;
      vecs[2].wr = 0; vecs[2].a = 15'd5;
      vecs[3].wr = 1; vecs[3].a = 15'h7FFF;
      vecs[4].wr = 0; vecs[4].a = 15'h7FFF;
      vecs[5].wr = 0; vecs[5].a = 15'h7FFE;
      vecs[6].wr = 0; vecs[6].a = 15'd0;
      vecs[7].wr = 0; vecs[7].a = 15'd1;
      vecs[8].wr = 0; vecs[8].a = 15'd1;

      R = 1'b0;
      c_in = 2'd0; a_in = '0; d_in = '0;
      c1_in = 2'd0; a1_in = '0; d1_in = '0;
      tick();
      tick();
      chk("rst cout", c_out, 0);
      chk("rst dout", d_out, 0);
      chk("rst busy", busy, 0);
      chk("rst busy1", busy1, 0);
      R = 1'b1;
      tick();

      do_op(vecs[0], 1'b0, "rd a1");
      chk("rd a1 beat0 const", rd_beats[0], 16'hB4B5);
      chk("rd a1 beat7 const", rd_beats[7], 16'hBABB);

      for (int k = 1; k < 7; k++) begin
         do_op(vecs[k], 1'b0, $sformatf("vec%0d", k));
      end

      do_op(vecs[7], 1'b1, "rd a1 ignore wr");
      do_op(vecs[8], 1'b0, "rd a1 again");

      c_in = 2'd3; a_in = 15'd2; d_in = 16'h1111;
      tick();
      c_in = 2'd0; d_in = 16'h2222;
      tick();
      d_in = 16'h3333;
      tick();
      d_in = 16'h4444;
      R = 1'b0;
      tick();
      chk("mid rst cout", c_out, 0);
      chk("mid rst dout", d_out, 0);
      chk("mid rst busy", busy, 0);
      R = 1'b1;
      d_in = 16'h5555;
      tick();
      d_in = 16'h0;
      begin
         vec_t v;
         v.wr = 0;
         v.a = 15'd2;
         for (int i = 0; i < 8; i++) v.d[i] = seed16(15'd2, i);
         do_op(v, 1'b0, "rd a2 after rst");
      end
      chk("rd a2 beat0 const", rd_beats[0], 16'h8485);

      c1_in = 2'd2; a1_in = 15'd0;
      tick();
      c1_in = 2'd0;
      chk("u1 rd busy", busy1, 1);
      chk("u1 rd cout0", c1_out, 0);
      tick();
      chk("u1 rd cout", c1_out, 1);
      chk("u1 rd line", d1_out, seed128(15'd0));
      chk("u1 rd busy2", busy1, 1);
      tick();
      chk("u1 rd done busy", busy1, 0);
      chk("u1 rd done cout", c1_out, 0);

      c1_in = 2'd3; a1_in = 15'd7;
      d1_in = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      tick();
      c1_in = 2'd0; d1_in = '0;
      chk("u1 wr busy", busy1, 1);
      tick();
      chk("u1 wr ack", c1_out, 1);
      chk("u1 wr ack dout", d1_out, 0);
      tick();
      chk("u1 wr done", busy1, 0);
      c1_in = 2'd2; a1_in = 15'd7;
      tick();
      c1_in = 2'd0;
      tick();
      chk("u1 rdback cout", c1_out, 1);
      chk("u1 rdback line", d1_out,
          128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/line_mem_ctrl.md
Name: line_mem_ctrl

Overview:
- Cycle-accurate, parametrised main-memory model for the cache hierarchy.
- Serves whole cache lines over a narrow command/data bus, with a configurable access latency and multi-beat bursts.
- Replaces the instantaneous task/function-call memory access with a clocked handshake that the cache controller drives cycle by cycle.
- Sits between the cache controller and the testbench.

Parameters:
- ADDR_W, 15: line-address width (tag+set bits); depth = 2^ADDR_W lines.
- LINE_BYTES, 16: bytes per cache line.
- BUS_W, 16: data-bus width in bits; BEATS = LINE_BYTES*8/BUS_W (default 8). BUS_W must divide LINE_BYTES*8.
- LATENCY, 100: cycles from command acceptance to first response cycle; must be ≥1.
- SEED, 8'hA5: init pattern; byte at byte address b = b[7:0] ^ SEED.

Ports:
- clk  in  1  rising-edge clock.
- R  in  1  synchronous active-low reset (sampled on clk; 0 = reset).
- c_in  in  2  command from cache: 0 NOP, 2 READ_LINE, 3 WRITE_LINE (1 reserved, treated as NOP).
- a_in  in  ADDR_W  line address, sampled on the command cycle only.
- d_in  in  BUS_W  write-data beats.
- c_out  out  2  0 NOP, 1 RESPONSE.
- d_out  out  BUS_W  read-data beat; 0 whenever c_out != RESPONSE.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (R=0 at an edge): state → IDLE; c_out=0, d_out=0, busy=0; counters cleared.
- Memory array is NOT touched by reset; it is loaded with the SEED pattern at time 0 only.
- Reset mid-operation aborts the operation. Partially collected write beats are discarded, and memory is unchanged unless the commit edge has already occurred.
- Beat order: beat i carries line bytes [i*BUS_W/8 .. (i+1)*BUS_W/8-1], little-endian (lower byte address in d[7:0]).
- States: IDLE, WR_COLLECT, WAIT, RD_RESP, WR_ACK.
- IDLE:
  - c_in=READ_LINE at edge k: latch a_in, set op=RD, load wait counter, → WAIT.
  - c_in=WRITE_LINE at edge k: latch a_in, capture d_in as beat 0, → WR_COLLECT (→ commit directly if BEATS=1).
  - NOP/reserved: stay in IDLE.
- WR_COLLECT:
  - Captures d_in at edges k+1..k+BEATS-1; c_in is ignored.
  - At edge k+BEATS-1 the full line is written atomically to memory, then → WAIT.
- WAIT:
  - Counts down so that c_out=RESPONSE first appears exactly LATENCY edges after the command (read) or after the commit edge (write).
  - Read: c_out=1 in cycles following edges k+LATENCY .. k+LATENCY+BEATS-1.
  - Write: c_out=1 for one cycle after edge k+BEATS-1+LATENCY.
- RD_RESP:
  - c_out=1 and d_out=beat i for BEATS consecutive cycles, with no gaps.
  - At edge k+LATENCY+BEATS → IDLE; busy falls on that edge.
- Read data is snapshotted at the command edge. A write committed elsewhere cannot occur, because single-outstanding operation is enforced.
- WR_ACK: one cycle of c_out=1, d_out=0, then → IDLE.
- Commands while busy=1 are ignored and have no side effects. The cache must hold its command until busy=0 and must not re-issue during RESPONSE.
- A command may be accepted on the first edge at which the state is IDLE, including the edge right after the last RESPONSE cycle.
- Address arithmetic:
  - Byte address = {a, offset}, with offset width log2(LINE_BYTES).
  - Line addresses wrap naturally at 2^ADDR_W; no out-of-range case exists.
- Counters are sized ≥ clog2(LATENCY+BEATS+1) bits; no overflow is possible.

Test Plan:
- Reset then READ_LINE a=1 (defaults):
  - busy=1 next cycle, c_out=0 for exactly 100 cycles.
  - Then 8 RESPONSE beats: beat0=16'hB4B5 (0x11^A5, 0x10^A5), beat7=16'hBABB.
  - busy=0 after the last beat.
- WRITE_LINE a=5 with beats 16'h0001..16'h0008 on consecutive cycles:
  - c_out=RESPONSE for exactly one cycle, 100 cycles after the 8th beat edge.
  - A following READ_LINE a=5 returns 0001..0008 in order.
- While busy from READ a=1, drive WRITE_LINE a=1 with beats FFFF:
  - Ignored; the read returns the seed data.
  - A later read of a=1 still returns the seed data.
- R=0 during the 4th beat of WRITE_LINE a=2:
  - Outputs are 0 on the next cycle.
  - A subsequent READ a=2 returns the seed data (0x20^A5=0x85 → beat0=16'h8485).
- Back-to-back ops: issue READ a=0 on the first edge after busy falls from a prior read.
  - The new read is accepted and its response latency is exactly 100 cycles.
- Parameter sweep LATENCY=1, BUS_W=128 (BEATS=1):
  - READ a=0 gives c_out=1 on the cycle after acceptance, with d_out = the full line; busy is high for exactly 2 cycles.
